// File: rtl/bus_router_n_if.sv
// Master-side and slave-side signal bundle for bus_router_n.
// The router takes the slave modport; the environment takes the master modport.
interface bus_router_n_if #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16
);
    localparam int SLV_AW = ADDR_W - SEL_W;

    logic                         m_sel;
    logic                         m_enable;
    logic                         m_wr;
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W-1:0]            m_wdata;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_ready;
    logic                         m_err;
    logic [NUM_SLAVES-1:0]        s_sel;
    logic [NUM_SLAVES-1:0]        s_enable;
    logic                         s_wr;
    logic [SLV_AW-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_ready;

    modport slave (
        input  m_sel, m_enable, m_wr, m_addr, m_wdata,
        input  s_rdata, s_ready,
        output m_rdata, m_ready, m_err,
        output s_sel, s_enable, s_wr, s_addr, s_wdata
    );

    modport master (
        output m_sel, m_enable, m_wr, m_addr, m_wdata,
        output s_rdata, s_ready,
        input  m_rdata, m_ready, m_err,
        input  s_sel, s_enable, s_wr, s_addr, s_wdata
    );
endinterface

// File: rtl/bus_router_n.sv
// Setup/access router from one master to NUM_SLAVES slaves with timeout and decode error.
// Define BUS_ROUTER_ERR_CNT_EN to add the saturating err_cnt output.
module bus_router_n #(
    parameter int NUM_SLAVES  = 4,
    parameter int SEL_W       = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_router_n_if.slave      bus
`ifdef BUS_ROUTER_ERR_CNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);
    localparam int SLV_AW = ADDR_W - SEL_W;
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [SEL_W:0] NS_L = (SEL_W + 1)'(NUM_SLAVES);
    localparam logic [NUM_SLAVES-1:0] ONE = NUM_SLAVES'(1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [SLV_AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [NUM_SLAVES-1:0] en_q, en_d;

    logic [SEL_W-1:0]      m_idx;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  slave_rdy;
    logic                  timeout;

    assign m_idx     = bus.m_addr[ADDR_W-1 -: SEL_W];
    // en_q is only non-zero in ACCESS, so other slaves' ready is masked off
    assign slave_rdy = |(bus.s_ready & en_q);
    assign timeout   = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        sel_d   = sel_q;
        en_d    = en_q;
        unique case (state_q)
            IDLE: begin
                if (bus.m_sel && !bus.m_enable) begin
                    wr_d   = bus.m_wr;
                    addr_d = bus.m_addr[SLV_AW-1:0];
                    if (bus.m_wr) wdata_d = bus.m_wdata;
                    if ({1'b0, m_idx} < NS_L) begin
                        state_d = SETUP;
                        sel_d   = ONE << m_idx;
                    end else begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        if (!bus.m_wr) rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
                en_d    = sel_q;
            end
            ACCESS: begin
                if (slave_rdy) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    sel_d   = '0;
                    en_d    = '0;
                    if (!wr_q) rdata_d = sel_rdata;
                end else if (timeout) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    en_d    = '0;
                    if (!wr_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
        end
    end

    assign bus.m_rdata  = rdata_q;
    assign bus.m_ready  = ready_q;
    assign bus.m_err    = err_q;
    assign bus.s_sel    = sel_q;
    assign bus.s_enable = en_q;
    assign bus.s_wr     = wr_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;

`ifdef BUS_ROUTER_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (state_q == RESP && err_q && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bus_router_n.sv
// Bench for bus_router_n: 3 slaves with programmable wait states, directed and random transfers.
// Expected results come from a transfer-level model (latency, enable count, error, memory map).
module tb_bus_router_n;
    localparam int NS = 3;
    localparam int SW = 2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_router_n_if #(.NUM_SLAVES(NS), .SEL_W(SW), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef BUS_ROUTER_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    bus_router_n #(
        .NUM_SLAVES(NS), .SEL_W(SW), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef BUS_ROUTER_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    // Slave models: 64-word memories, ready after wait_cyc access cycles
    logic [DW-1:0] mem [NS][64];
    int            acc;
    int            wait_cyc;
    logic [NS-1:0] noise;

    always @(posedge clk) begin
        acc <= (|bus.s_enable) ? acc + 1 : 0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < 64; j++) begin
                if (!rst_n) mem[i][j] <= '0;
            end
            if (rst_n && bus.s_sel[i] && bus.s_enable[i] && bus.s_ready[i] && bus.s_wr)
                mem[i][bus.s_addr[5:0]] <= bus.s_wdata;
        end
    end

    always_comb begin
        bus.s_ready = '0;
        bus.s_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            bus.s_ready[i] = (bus.s_sel[i] && bus.s_enable[i]) ? (acc >= wait_cyc) : noise[i];
            bus.s_rdata[i*DW +: DW] = mem[i][bus.s_addr[5:0]];
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_rd;
    int            n_err;

    logic [DW-1:0] r_rdata;
    logic          r_err;
    int            r_lat;
    int            r_ens;
    logic [NS-1:0] r_sel;
    logic [NS-1:0] r_en1;
    logic [13:0]   r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        @(posedge clk);
        #1;
        bus.m_sel = 1'b1;
        bus.m_enable = 1'b0;
        bus.m_wr = wr;
        bus.m_addr = a;
        bus.m_wdata = d;
        @(posedge clk);
        #1 bus.m_enable = 1'b1;
        got = 0;
        r_lat = 0;
        r_ens = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                r_sel = bus.s_sel;
                r_en1 = bus.s_enable;
                r_addr = bus.s_addr;
                r_wdata = bus.s_wdata;
                r_wr = bus.s_wr;
            end
            if (|bus.s_enable) r_ens++;
            if (bus.m_ready) begin
                got = 1;
                r_lat = c;
                r_rdata = bus.m_rdata;
                r_err = bus.m_err;
            end
        end
        chk("ready_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk("ready_pulse", 32'(bus.m_ready), 32'd0);
        #1;
        bus.m_sel = 1'b0;
        bus.m_enable = 1'b0;
    endtask

    task automatic run(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int w);
        int  idx;
        int  key;
        int  ew;
        bit  dec;
        bit  expe;
        idx = int'(a[15:14]);
        key = idx * 64 + int'(a[5:0]);
        dec = idx >= NS;
        ew = (w > TO - 1) ? TO - 1 : w;
        expe = dec || (w >= TO);
        wait_cyc = w;
        noise = NS'($urandom);
        xfer(wr, a, d);
        chk("latency", 32'(r_lat), 32'(dec ? 1 : 3 + ew));
        chk("enable_cycles", 32'(r_ens), 32'(dec ? 0 : ew + 1));
        chk("setup_sel", 32'(r_sel), dec ? 32'd0 : 32'(1 << idx));
        chk("setup_en", 32'(r_en1), 32'd0);
        chk("m_err", 32'(r_err), 32'(expe));
        if (!wr) begin
            if (expe) exp_rd = '0;
            else exp_rd = ref_mem.exists(key) ? ref_mem[key] : '0;
        end else if (!expe) begin
            ref_mem[key] = d;
        end
        chk("m_rdata", 32'(r_rdata), 32'(exp_rd));
        if (expe) n_err++;
`ifdef BUS_ROUTER_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'((n_err > 255) ? 255 : n_err));
`endif
    endtask

    initial begin
        bus.m_sel = 1'b0;
        bus.m_enable = 1'b0;
        bus.m_wr = 1'b0;
        bus.m_addr = '0;
        bus.m_wdata = '0;
        wait_cyc = 0;
        noise = '0;
        exp_rd = '0;
        n_err = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", 32'(bus.m_rdata), 32'd0);
        chk("rst_ready", 32'(bus.m_ready), 32'd0);
        chk("rst_err", 32'(bus.m_err), 32'd0);
        chk("rst_sel", 32'(bus.s_sel), 32'd0);
        chk("rst_en", 32'(bus.s_enable), 32'd0);
        chk("rst_swr", 32'(bus.s_wr), 32'd0);
        chk("rst_saddr", 32'(bus.s_addr), 32'd0);
        chk("rst_swdata", 32'(bus.s_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b1, 16'h4123, 16'hBEEF, 0);
        chk("wr_sel", 32'(r_sel), 32'h2);
        chk("wr_saddr", 32'(r_addr), 32'h0123);
        chk("wr_swdata", 32'(r_wdata), 32'hBEEF);
        chk("wr_swr", 32'(r_wr), 32'd1);
        run(1'b0, 16'h4123, 16'h0000, 0);
        chk("rd_beef", 32'(r_rdata), 32'hBEEF);
        chk("rd_lat3", 32'(r_lat), 32'd3);

        run(1'b1, 16'h8005, 16'h1234, 0);
        run(1'b0, 16'h8005, 16'h0000, 3);
        chk("ws_en4", 32'(r_ens), 32'd4);
        chk("ws_data", 32'(r_rdata), 32'h1234);

        run(1'b0, 16'hC000, 16'h0000, 0);
        chk("dec_err", 32'(r_err), 32'd1);
        chk("dec_lat", 32'(r_lat), 32'd1);

        run(1'b1, 16'h0010, 16'h5A5A, 0);
        run(1'b0, 16'h4123, 16'h0000, 0);
        run(1'b0, 16'h0010, 16'h0000, 100);
        chk("to_en8", 32'(r_ens), 32'd8);
        chk("to_data0", 32'(r_rdata), 32'd0);
        run(1'b0, 16'h0010, 16'h0000, 7);
        chk("last_ok", 32'(r_err), 32'd0);
        chk("last_data", 32'(r_rdata), 32'h5A5A);

        for (int k = 0; k < 40; k++) begin
            int idx;
            int w;
            idx = $urandom_range(0, 3);
            w = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
            run(1'($urandom), {2'(idx), 8'h00, 6'($urandom_range(0, 7))}, 16'($urandom), w);
        end

        run(1'b0, 16'h4123, 16'h0000, 0);
        wait_cyc = 100;
        noise = '0;
        @(posedge clk);
        #1;
        bus.m_sel = 1'b1;
        bus.m_enable = 1'b0;
        bus.m_wr = 1'b0;
        bus.m_addr = 16'h0010;
        @(posedge clk);
        #1 bus.m_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_en", 32'(bus.s_enable), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(bus.s_sel), 32'd0);
        chk("mid_rst_en", 32'(bus.s_enable), 32'd0);
        chk("mid_rst_ready", 32'(bus.m_ready), 32'd0);
        chk("mid_rst_rdata", 32'(bus.m_rdata), 32'd0);
        bus.m_sel = 1'b0;
        bus.m_enable = 1'b0;
        ref_mem.delete();
        exp_rd = '0;
        n_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(1'b1, 16'h0001, 16'h0A5C, 0);
        run(1'b0, 16'h0001, 16'h0000, 0);
        chk("post_rst_data", 32'(r_rdata), 32'h0A5C);

`ifdef BUS_ROUTER_ERR_CNT_EN
        run(1'b0, 16'h0010, 16'h0000, 100);
        run(1'b0, 16'h0010, 16'h0000, 100);
        run(1'b0, 16'hC000, 16'h0000, 0);
        chk("err_cnt3", 32'(err_cnt), 32'd3);
        for (int k = 0; k < 260; k++) run(1'b0, 16'hC000, 16'h0000, 0);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
